// File: rtl/uart_rx_capture.sv
// uart_rx_capture: 16x oversampled UART receiver with a ready/valid FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at counts 6/7/8.
module uart_rx_capture #(
   parameter int         CLK_DIV    = 27,
   parameter int         DATA_BITS  = 8,
   parameter int         PARITY     = 0,
   parameter int         STOP_BITS  = 1,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] END_CHAR   = 8'h04
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        RXD,
   output logic [DATA_BITS-1:0]        RX_DATA,
   output logic                        RX_VALID,
   input  logic                        RX_READY,
   output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
   output logic                        FRAME_ERR,
   output logic                        PARITY_ERR,
   output logic                        OVERFLOW,
   output logic                        SIMULATIONEND
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [DATA_BITS-1:0] END_VAL = END_CHAR[DATA_BITS-1:0];
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] DEC_CNT = 4'd8;
`else
   localparam logic [3:0] DEC_CNT = 4'd7;
`endif

   typedef enum logic [2:0] {
      S_WAIT_IDLE,
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_e;

   logic                 rxd_meta_q;
   logic                 rxd_sync_q;
   logic [15:0]          tick_cnt_q;
   logic [15:0]          tick_cnt_d;
   logic                 tick;
   state_e               state_q;
   logic [3:0]           samp_q;
   logic [2:0]           bit_idx_q;
   logic                 stop_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 frame_err_q;
   logic                 parity_err_q;
   logic                 sim_end_q;
   logic                 bit_val;
   logic                 dec;
   logic                 bit_end;
   logic                 final_stop;
   logic                 par_ok;
   logic                 stop_dec;
   logic                 good;
   logic                 idle_exit;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;
   logic                 ovf_q;
   logic                 full;
   logic                 pop;
   logic                 wr_en;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
      end else begin
         rxd_meta_q <= RXD;
         rxd_sync_q <= rxd_meta_q;
      end
   end

   assign tick      = (tick_cnt_q == DIV_MAX);
   assign idle_exit = (state_q == S_IDLE) && !rxd_sync_q;

   // Restart the oversample phase on the falling start edge.
   always_comb begin
      tick_cnt_d = tick_cnt_q + 16'd1;
      if (idle_exit || tick) tick_cnt_d = '0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) tick_cnt_q <= '0;
      else       tick_cnt_q <= tick_cnt_d;
   end

`ifdef UART_RX_MAJORITY_EN
   logic s6_q;
   logic s7_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s6_q <= 1'b1;
         s7_q <= 1'b1;
      end else if (tick) begin
         if (samp_q == 4'd6) s6_q <= rxd_sync_q;
         if (samp_q == 4'd7) s7_q <= rxd_sync_q;
      end
   end

   assign bit_val = (s6_q & s7_q) | (s6_q & rxd_sync_q) |
                    (s7_q & rxd_sync_q);
`else
   assign bit_val = rxd_sync_q;
`endif

   assign dec        = tick && (samp_q == DEC_CNT);
   assign bit_end    = tick && (samp_q == 4'd15);
   assign final_stop = (STOP_BITS == 1) || stop_idx_q;
   assign stop_dec   = (state_q == S_STOP) && dec;
   assign good       = stop_dec && bit_val && final_stop && par_ok;

   always_comb begin
      par_ok = 1'b1;
      if (PARITY == 1)      par_ok = ~(^shift_q ^ par_q);
      else if (PARITY == 2) par_ok = ^shift_q ^ par_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_WAIT_IDLE;
         samp_q       <= '0;
         bit_idx_q    <= '0;
         stop_idx_q   <= 1'b0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         sim_end_q    <= 1'b0;
      end else begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         if (good && (shift_q == END_VAL)) sim_end_q <= 1'b1;
         unique case (state_q)
            S_WAIT_IDLE: begin
               if (tick && rxd_sync_q) state_q <= S_IDLE;
            end
            S_IDLE: begin
               if (!rxd_sync_q) begin
                  state_q <= S_START;
                  samp_q  <= '0;
               end
            end
            S_START: begin
               if (tick) samp_q <= samp_q + 4'd1;
               if (dec && bit_val) begin
                  state_q <= S_IDLE;
               end else if (bit_end) begin
                  state_q   <= S_DATA;
                  bit_idx_q <= '0;
               end
            end
            S_DATA: begin
               if (tick) samp_q <= samp_q + 4'd1;
               if (dec) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_idx_q == LAST_BIT) begin
                     state_q    <= (PARITY != 0) ? S_PAR : S_STOP;
                     stop_idx_q <= 1'b0;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end
            end
            S_PAR: begin
               if (tick) samp_q <= samp_q + 4'd1;
               if (dec) par_q <= bit_val;
               if (bit_end) begin
                  state_q    <= S_STOP;
                  stop_idx_q <= 1'b0;
               end
            end
            S_STOP: begin
               if (tick) samp_q <= samp_q + 4'd1;
               // Leave at the final sample, not the bit end, for resync margin.
               if (dec && !bit_val) begin
                  frame_err_q  <= 1'b1;
                  parity_err_q <= !par_ok;
                  state_q      <= S_WAIT_IDLE;
               end else if (dec && final_stop) begin
                  parity_err_q <= !par_ok;
                  state_q      <= S_IDLE;
               end else if (bit_end) begin
                  stop_idx_q <= 1'b1;
               end
            end
            default: state_q <= S_WAIT_IDLE;
         endcase
      end
   end

   assign full  = (count_q == FULL_CNT);
   assign pop   = (count_q != '0) && RX_READY;
   assign wr_en = good && (!full || pop);

   always_comb begin
      count_d = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en)         wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)           rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (good && !wr_en) ovf_q   <= 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= shift_q;
   end

   assign RX_VALID      = (count_q != '0);
   assign RX_DATA       = RX_VALID ? mem_q[rd_ptr_q] : '0;
   assign FIFO_COUNT    = count_q;
   assign FRAME_ERR     = frame_err_q;
   assign PARITY_ERR    = parity_err_q;
   assign OVERFLOW      = ovf_q;
   assign SIMULATIONEND = sim_end_q;

endmodule
